// File: rtl/core_sys_mem_pkg.sv
// Shared definitions for the dual-port on-chip memory block.
//   clr_state_t : zeroize FSM encoding (IDLE, CLEAR)
//   COLL_W      : width of the saturating same-address collision counter
package core_sys_mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  localparam int COLL_W = 16;

endpackage

// File: rtl/core_sys_tdp_ram_core.sv
// Inferred true-dual-port byte-enabled RAM, single clock.
// Read data is the synchronous-read register of the array with no extra
// output stage. A read that hits an address written by the other port in the
// same cycle returns the old contents.
//   clk, reset_n         : clock, synchronous active-low reset (read regs only)
//   enN                  : port N read-register enable (holds qN when low)
//   weN, addrN, beN      : port N write strobe, word address, lane enables
//   wdataN / qN          : port N write data / read data
module core_sys_tdp_ram_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8192,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [BE_W-1:0]   be1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] q1,
  input  logic              en2,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [BE_W-1:0]   be2,
  input  logic [DATA_W-1:0] wdata2,
  output logic [DATA_W-1:0] q2
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Port 1 is written last so it owns any lane both ports touch.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (we2 && be2[b]) mem[addr2][b*8 +: 8] <= wdata2[b*8 +: 8];
      if (we1 && be1[b]) mem[addr1][b*8 +: 8] <= wdata1[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q1 <= '0;
      q2 <= '0;
    end else begin
      if (en1) q1 <= mem[addr1];
      if (en2) q2 <= mem[addr2];
    end
  end

endmodule

// File: rtl/core_sys_onchip_memory_dp.sv
// Dual-port Avalon-MM on-chip memory with zeroize sweep and collision counter.
//   clk, reset_n                  : clock, synchronous active-low reset
//   addressN, chipselectN, readN,
//   writeN, byteenableN,
//   writedataN, clkenN           : port N command inputs (N = 1, 2)
//   readdataN, readdatavalidN,
//   waitrequestN                 : port N response outputs
//   clear_req / clear_busy       : zeroize request / sweep in progress
//   collision_count              : saturating count of same-address dual writes
//
// Clear FSM
//   state    | meaning
//   ST_IDLE  | normal operation, clear request latched until reads drain
//   ST_CLEAR | writing zero to one word per cycle through the port-1 path
module core_sys_onchip_memory_dp
  import core_sys_mem_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 8192,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address1,
  input  logic              chipselect1,
  input  logic              read1,
  input  logic              write1,
  input  logic [BE_W-1:0]   byteenable1,
  input  logic [DATA_W-1:0] writedata1,
  input  logic              clken1,
  output logic [DATA_W-1:0] readdata1,
  output logic              readdatavalid1,
  output logic              waitrequest1,
  input  logic [ADDR_W-1:0] address2,
  input  logic              chipselect2,
  input  logic              read2,
  input  logic              write2,
  input  logic [BE_W-1:0]   byteenable2,
  input  logic [DATA_W-1:0] writedata2,
  input  logic              clken2,
  output logic [DATA_W-1:0] readdata2,
  output logic              readdatavalid2,
  output logic              waitrequest2,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [COLL_W-1:0] collision_count
);

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_pend;
  logic              clearing;

  logic acc1, acc2, acc_wr1, acc_wr2, acc_rd1, acc_rd2;
  logic collide, rd_busy;
  logic s1_1, s1_2;
  logic [DATA_W-1:0] q1, q2, dreg1, dreg2;

  logic              ram_we1;
  logic [ADDR_W-1:0] ram_addr1;
  logic [BE_W-1:0]   ram_be1;
  logic [DATA_W-1:0] ram_wdata1;

  assign clearing     = (state == ST_CLEAR);
  assign clear_busy   = clearing;
  assign waitrequest1 = clearing;
  assign waitrequest2 = clearing;

  // A command with both read and write set is a write.
  assign acc1    = chipselect1 & (read1 | write1) & clken1 & ~waitrequest1;
  assign acc2    = chipselect2 & (read2 | write2) & clken2 & ~waitrequest2;
  assign acc_wr1 = acc1 & write1;
  assign acc_wr2 = acc2 & write2;
  assign acc_rd1 = acc1 & ~write1;
  assign acc_rd2 = acc2 & ~write2;

  assign collide = acc_wr1 & acc_wr2 & (address1 == address2);

  // Reads still in flight: accepted this cycle, or parked in the first stage.
  assign rd_busy = acc_rd1 | acc_rd2 | ((OUT_REG != 0) & (s1_1 | s1_2));

  // The sweep borrows the port-1 write path regardless of clken1.
  assign ram_we1    = clearing | acc_wr1;
  assign ram_addr1  = clearing ? clr_addr : address1;
  assign ram_be1    = clearing ? '1 : byteenable1;
  assign ram_wdata1 = clearing ? '0 : writedata1;

  core_sys_tdp_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .en1     (clken1),
    .we1     (ram_we1),
    .addr1   (ram_addr1),
    .be1     (ram_be1),
    .wdata1  (ram_wdata1),
    .q1      (q1),
    .en2     (clken2),
    .we2     (acc_wr2 & ~collide),
    .addr2   (address2),
    .be2     (byteenable2),
    .wdata2  (writedata2),
    .q2      (q2)
  );

  // Valid pipeline advances only with clken; a stalled cycle forces valid low
  // and the parked read is presented once the port is enabled again.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_1           <= 1'b0;
      s1_2           <= 1'b0;
      readdatavalid1 <= 1'b0;
      readdatavalid2 <= 1'b0;
      dreg1          <= '0;
      dreg2          <= '0;
    end else begin
      if (clken1) begin
        s1_1           <= acc_rd1;
        readdatavalid1 <= (OUT_REG != 0) ? s1_1 : acc_rd1;
        dreg1          <= q1;
      end else begin
        readdatavalid1 <= 1'b0;
      end
      if (clken2) begin
        s1_2           <= acc_rd2;
        readdatavalid2 <= (OUT_REG != 0) ? s1_2 : acc_rd2;
        dreg2          <= q2;
      end else begin
        readdatavalid2 <= 1'b0;
      end
    end
  end

  assign readdata1 = (OUT_REG != 0) ? dreg1 : q1;
  assign readdata2 = (OUT_REG != 0) ? dreg2 : q2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr <= '0;
      clr_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((clear_req | clr_pend) & ~rd_busy) begin
            state    <= ST_CLEAR;
            clr_pend <= 1'b0;
            clr_addr <= '0;
          end else if (clear_req) begin
            clr_pend <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == ADDR_W'(DEPTH - 1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      collision_count <= '0;
    end else if (collide && (collision_count != '1)) begin
      collision_count <= collision_count + COLL_W'(1);
    end
  end

endmodule

// File: tb/tb_core_sys_onchip_memory_dp.sv
// Directed bench for core_sys_onchip_memory_dp. Two instances share one
// stimulus stream: index 0 has OUT_REG=0 (latency 1), index 1 has OUT_REG=1
// (latency 2). Both are DATA_W=32, DEPTH=16, CLEAR_ON_RESET=1.
module tb_core_sys_onchip_memory_dp;

  logic        clk;
  logic        reset_n;
  logic [3:0]  address1, address2;
  logic        chipselect1, chipselect2, read1, read2, write1, write2;
  logic [3:0]  byteenable1, byteenable2;
  logic [31:0] writedata1, writedata2;
  logic        clken1, clken2;
  logic        clear_req;

  logic [31:0] rdat [0:1][1:2];
  logic        rdv  [0:1][1:2];
  logic        wrq  [0:1][1:2];
  logic        busy [0:1];
  logic [15:0] ccnt [0:1];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    core_sys_onchip_memory_dp #(
      .DATA_W(32), .DEPTH(16), .OUT_REG(g), .CLEAR_ON_RESET(1)
    ) u_dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .address1        (address1),
      .chipselect1     (chipselect1),
      .read1           (read1),
      .write1          (write1),
      .byteenable1     (byteenable1),
      .writedata1      (writedata1),
      .clken1          (clken1),
      .readdata1       (rdat[g][1]),
      .readdatavalid1  (rdv[g][1]),
      .waitrequest1    (wrq[g][1]),
      .address2        (address2),
      .chipselect2     (chipselect2),
      .read2           (read2),
      .write2          (write2),
      .byteenable2     (byteenable2),
      .writedata2      (writedata2),
      .clken2          (clken2),
      .readdata2       (rdat[g][2]),
      .readdatavalid2  (rdv[g][2]),
      .waitrequest2    (wrq[g][2]),
      .clear_req       (clear_req),
      .clear_busy      (busy[g]),
      .collision_count (ccnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect1 = 0; read1 = 0; write1 = 0; address1 = '0; byteenable1 = '0; writedata1 = '0;
    chipselect2 = 0; read2 = 0; write2 = 0; address2 = '0; byteenable2 = '0; writedata2 = '0;
    clken1 = 1; clken2 = 1; clear_req = 0;
  endtask

  task automatic drive(input int port, input logic rd, input logic wr, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (port == 1) begin
      chipselect1 = 1; read1 = rd; write1 = wr; address1 = a; writedata1 = d; byteenable1 = be;
    end else begin
      chipselect2 = 1; read2 = rd; write2 = wr; address2 = a; writedata2 = d; byteenable2 = be;
    end
  endtask

  task automatic do_write(input int port, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(port, 1'b0, 1'b1, a, d, be);
    cyc();
    idle();
  endtask

  // Watches offsets 1..4 after a command cycle on one port of both instances.
  task automatic collect(input int port, input int exp_n, input logic [31:0] exp_d, input string tag);
    int np [0:1];
    int lat [0:1];
    logic [31:0] dv [0:1];
    for (int g = 0; g < 2; g++) begin np[g] = 0; lat[g] = 0; dv[g] = '0; end
    for (int k = 1; k <= 4; k++) begin
      for (int g = 0; g < 2; g++) begin
        if (rdv[g][port]) begin
          np[g]++;
          if (np[g] == 1) begin lat[g] = k; dv[g] = rdat[g][port]; end
        end
      end
      if (k < 4) cyc();
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_d%0d_pulses", tag, g), np[g], exp_n);
      if (exp_n > 0) begin
        chk($sformatf("%s_d%0d_lat", tag, g), lat[g], g + 1);
        chk($sformatf("%s_d%0d_data", tag, g), dv[g], exp_d);
      end
    end
  endtask

  task automatic do_read(input int port, input logic [3:0] a, input logic [31:0] exp_d, input string tag);
    drive(port, 1'b1, 1'b0, a, '0, '0);
    cyc();
    idle();
    collect(port, 1, exp_d, tag);
  endtask

  task automatic count_sweep(input string tag);
    int nb [0:1];
    logic wbad;
    nb[0] = 0; nb[1] = 0; wbad = 0;
    for (int k = 0; k < 40; k++) begin
      for (int g = 0; g < 2; g++) begin
        if (busy[g]) begin
          nb[g]++;
          if (!(wrq[g][1] && wrq[g][2])) wbad = 1;
        end else if (wrq[g][1] || wrq[g][2]) begin
          wbad = 1;
        end
      end
      cyc();
    end
    chk({tag, "_busy_d0"}, nb[0], 16);
    chk({tag, "_busy_d1"}, nb[1], 16);
    chk({tag, "_waitreq"}, wbad, 0);
  endtask

  initial begin
    logic [6:0]  tr [0:1];
    int          nv [0:1];
    logic [31:0] sd [0:1][0:1];
    int          vc [0:1];
    int          bc [0:1];
    int          nb [0:1];
    logic [31:0] vd [0:1];

    idle();
    reset_n = 0;
    repeat (3) cyc();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_valid1_d%0d", g), rdv[g][1], 0);
      chk($sformatf("rst_valid2_d%0d", g), rdv[g][2], 0);
      chk($sformatf("rst_rdata1_d%0d", g), rdat[g][1], 0);
      chk($sformatf("rst_ccnt_d%0d", g), ccnt[g], 0);
      chk($sformatf("rst_busy_d%0d", g), busy[g], 1);
    end
    reset_n = 1;
    count_sweep("init");

    for (int i = 0; i < 16; i++) do_read((i % 2) + 1, 4'(i), 32'h0, $sformatf("zero_a%0d", i));

    // Byte-lane merge.
    do_write(1, 4'd5, 32'hAABBCCDD, 4'hF);
    do_write(1, 4'd5, 32'h11223344, 4'h2);
    do_read(2, 4'd5, 32'hAABB33DD, "be_merge");

    // Same-address dual write: port 1 wins, counter bumps.
    drive(1, 1'b0, 1'b1, 4'd3, 32'h01, 4'hF);
    drive(2, 1'b0, 1'b1, 4'd3, 32'h02, 4'hF);
    cyc();
    idle();
    do_read(2, 4'd3, 32'h01, "coll_data");
    chk("coll_cnt_d0", ccnt[0], 1);
    chk("coll_cnt_d1", ccnt[1], 1);

    // Different-address dual write is not a collision.
    drive(1, 1'b0, 1'b1, 4'd8, 32'h12345678, 4'hF);
    drive(2, 1'b0, 1'b1, 4'd9, 32'h9ABCDEF0, 4'hF);
    cyc();
    idle();
    do_read(1, 4'd9, 32'h9ABCDEF0, "dual_a9");
    do_read(2, 4'd8, 32'h12345678, "dual_a8");
    chk("nocoll_cnt_d0", ccnt[0], 1);
    chk("nocoll_cnt_d1", ccnt[1], 1);

    // Mixed-port read during write returns old data.
    drive(1, 1'b0, 1'b1, 4'd7, 32'h55, 4'hF);
    drive(2, 1'b1, 1'b0, 4'd7, '0, '0);
    cyc();
    idle();
    collect(2, 1, 32'h0, "olddata");
    do_read(1, 4'd7, 32'h55, "newdata");

    // read=write=1 is a write: no read response.
    drive(2, 1'b1, 1'b1, 4'd10, 32'h77, 4'hF);
    cyc();
    idle();
    collect(2, 0, 32'h0, "rdwr_novalid");
    do_read(2, 4'd10, 32'h77, "rdwr_data");

    // Back-to-back port-1 reads with a one-cycle clken1 stall.
    drive(1, 1'b1, 1'b0, 4'd5, '0, '0);
    cyc();
    for (int g = 0; g < 2; g++) begin tr[g] = '0; nv[g] = 0; sd[g][0] = '0; sd[g][1] = '0; end
    for (int k = 1; k <= 6; k++) begin
      for (int g = 0; g < 2; g++) begin
        if (rdv[g][1]) begin
          tr[g][k] = 1'b1;
          if (nv[g] < 2) sd[g][nv[g]] = rdat[g][1];
          nv[g]++;
        end
      end
      if (k == 1) drive(1, 1'b1, 1'b0, 4'd3, '0, '0);
      if (k == 2) begin idle(); clken1 = 0; end
      if (k == 3) clken1 = 1;
      if (k < 6) cyc();
    end
    idle();
    chk("stall_trace_d0", 32'(tr[0]), 32'b0000110);
    chk("stall_trace_d1", 32'(tr[1]), 32'b0010100);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("stall_first_d%0d", g), sd[g][0], 32'hAABB33DD);
      chk($sformatf("stall_second_d%0d", g), sd[g][1], 32'h00000001);
    end

    // Clear request with a read in flight; a second request mid-sweep.
    drive(2, 1'b1, 1'b0, 4'd5, '0, '0);
    clear_req = 1;
    cyc();
    idle();
    for (int g = 0; g < 2; g++) begin vc[g] = 0; bc[g] = 0; nb[g] = 0; vd[g] = '0; end
    for (int k = 1; k <= 40; k++) begin
      for (int g = 0; g < 2; g++) begin
        if (rdv[g][2] && vc[g] == 0) begin vc[g] = k; vd[g] = rdat[g][2]; end
        if (busy[g]) begin
          if (bc[g] == 0) bc[g] = k;
          nb[g]++;
        end
      end
      clear_req = (k == 6);
      cyc();
    end
    idle();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("clr_valid_cyc_d%0d", g), vc[g], g + 1);
      chk($sformatf("clr_valid_data_d%0d", g), vd[g], 32'hAABB33DD);
      chk($sformatf("clr_busy_start_d%0d", g), bc[g], g + 2);
      chk($sformatf("clr_busy_len_d%0d", g), nb[g], 16);
    end
    do_read(1, 4'd5, 32'h0, "after_clr_a5");
    do_read(2, 4'd3, 32'h0, "after_clr_a3");

    // Reset in the middle of a sweep restarts it from address 0.
    do_write(2, 4'd15, 32'hDEADBEEF, 4'hF);
    clear_req = 1;
    cyc();
    clear_req = 0;
    repeat (4) cyc();
    reset_n = 0;
    cyc();
    cyc();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("midrst_busy_d%0d", g), busy[g], 1);
      chk($sformatf("midrst_ccnt_d%0d", g), ccnt[g], 0);
    end
    reset_n = 1;
    count_sweep("midrst");
    do_read(1, 4'd15, 32'h0, "midrst_a15");

    // Collision counter saturation.
    drive(1, 1'b0, 1'b1, 4'd0, 32'h11, 4'hF);
    drive(2, 1'b0, 1'b1, 4'd0, 32'h22, 4'hF);
    repeat (65540) cyc();
    idle();
    cyc();
    chk("sat_ccnt_d0", ccnt[0], 32'hFFFF);
    chk("sat_ccnt_d1", ccnt[1], 32'hFFFF);
    do_read(2, 4'd0, 32'h11, "sat_data");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_sys_onchip_memory_dp.md
CORE_SYS_ONCHIP_MEMORY_DP -- requirements
Module: core_sys_onchip_memory_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data width, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 8192: words, power of 2.
REQ-003 SHALL have parameter OUT_REG, default 0: 0 gives read latency 1, 1 gives read latency 2.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1: zeroize the array after reset.
REQ-005 SHALL derive localparams ADDR_W = clog2(DEPTH) and BE_W = DATA_W/8.
REQ-006 SHALL have port clk, input, 1: the only clock.
REQ-007 SHALL have port reset_n, input, 1: reset is synchronous and active-low.
REQ-008 SHALL have, for N=1,2, port addressN, input, ADDR_W: word address.
REQ-009 SHALL have, for N=1,2, ports chipselectN, readN, writeN, each input, 1: Avalon-MM strobes.
REQ-010 SHALL have, for N=1,2, port byteenableN, input, BE_W: write lane enables.
REQ-011 SHALL have, for N=1,2, port writedataN, input, DATA_W: write data.
REQ-012 SHALL have, for N=1,2, port clkenN, input, 1: port clock enable; low stalls the port.
REQ-013 SHALL have, for N=1,2, port readdataN, output, DATA_W: read data.
REQ-014 SHALL have, for N=1,2, port readdatavalidN, output, 1: readdataN is valid this cycle.
REQ-015 SHALL have, for N=1,2, port waitrequestN, output, 1: command not accepted.
REQ-016 SHALL have port clear_req, input, 1: start a zeroize sweep.
REQ-017 SHALL have port clear_busy, output, 1: zeroize in progress.
REQ-018 SHALL have port collision_count, output, 16: same-address dual-write events, saturating.

Function
REQ-019 SHALL accept a command on port N only when chipselectN & (readN | writeN) & clkenN & ~waitrequestN.
REQ-020 SHALL drive waitrequestN high only while clear_busy is high.
REQ-021 SHALL write only the byte lanes with byteenableN[i]=1; other lanes keep their contents.
REQ-022 SHALL return accepted-read data with readdatavalidN pulsing exactly 1+OUT_REG cycles after acceptance, one pulse per read, in order.
REQ-023 SHALL hold readdataN and the read pipeline while clkenN is low; readdatavalidN stays 0 during the stall, and the pending read completes after clkenN returns high.
REQ-024 SHALL return OLD_DATA on a read of an address that the other port writes in the same cycle.
REQ-025 SHALL, on a same-cycle read and write of one address on the same port, not occur: read and write are mutually exclusive; a command with readN=writeN=1 SHALL be treated as a write.
REQ-026 SHALL, when both ports write the same address in one cycle, apply the port-1 write, drop the port-2 write, and increment collision_count, saturating at 0xFFFF.
REQ-027 SHALL implement a clear FSM with states IDLE -> CLEAR -> IDLE:
- CLEAR writes zero to address 0..DEPTH-1, one word per cycle through the port-1 RAM path, ignoring clken1.
- The FSM returns to IDLE the cycle after address DEPTH-1 is written.
REQ-028 SHALL enter CLEAR from IDLE on clear_req=1 while no read is outstanding on either port; otherwise the request SHALL be held pending until the reads drain.
REQ-029 SHALL ignore clear_req while in CLEAR; a sweep is never restarted mid-way.
REQ-030 SHALL assert clear_busy exactly in CLEAR, for DEPTH cycles per sweep.

Reset
REQ-031 SHALL, on reset_n=0 at a clk edge, clear:
- readdataN, readdatavalidN and the read pipelines to 0;
- collision_count to 0;
- the clear address to 0.
REQ-032 SHALL leave reset in CLEAR if CLEAR_ON_RESET=1, otherwise in IDLE.
REQ-033 SHALL, on reset mid-sweep, restart the sweep from address 0 when CLEAR_ON_RESET=1, else abandon it with array contents undefined.

Structure
REQ-034 SHALL place the FSM state encoding (IDLE, CLEAR) and the collision counter width in shared package core_sys_mem_pkg.
REQ-035 SHALL instantiate one sub-module, core_sys_tdp_ram_core: an inferred true-dual-port byte-enabled RAM, one clock, unregistered output, OLD_DATA mixed-port behaviour.
REQ-036 SHALL contain in the top level only the handshake, the read pipeline, the collision logic, the clear FSM and the counter.

Verification
REQ-037 SHALL cover: DEPTH=16, CLEAR_ON_RESET=1, reset released -> clear_busy high for 16 cycles, waitrequest1/2 high; then reads of 0..15 return 0.
REQ-038 SHALL cover: DATA_W=32, write1 addr 5 data 0xAABBCCDD be 0xF, then write1 addr 5 data 0x11223344 be 0x2 -> read2 addr 5 returns 0xAABB33DD.
REQ-039 SHALL cover: both ports write addr 3 in one cycle (0x01 on port 1, 0x02 on port 2) -> read returns 0x01, collision_count=1.
REQ-040 SHALL cover: port 1 writes 0x55 to addr 7 (old 0x00) while port 2 reads addr 7 in the same cycle -> readdata2=0x00; a later read returns 0x55.
REQ-041 SHALL cover: OUT_REG=1, reads accepted at cycles 10 and 11, clken1 low in cycle 12 -> valid pulses at cycles 12 and 14.
REQ-042 SHALL cover: clear_req pulsed with a read outstanding -> CLEAR entered only after readdatavalid; a second clear_req mid-sweep has no effect.
